// File: rtl/multicycle_ctrl.sv
// multicycle_ctrl: fetch/decode/execute/memory/write-back sequencer for the
// RV32I multi-cycle core. Only the state and the retired-instruction count
// are registered; all control lines decode from state and the live inputs.
module multicycle_ctrl (
  input  logic        clk,
  input  logic        reset,
  input  logic [31:0] inst,
  input  logic        imem_ready,
  input  logic        dmem_ready,
  input  logic        branch_taken,
  output logic        imem_req,
  output logic        ir_we,
  output logic        pc_we,
  output logic [1:0]  pc_src,
  output logic        alu_a_sel,
  output logic        alu_b_sel,
  output logic        rf_we,
  output logic [1:0]  wb_sel,
  output logic        dmem_req,
  output logic        dmem_we,
  output logic        illegal,
  output logic [31:0] instret,
  output logic [2:0]  state
);

  typedef enum logic [2:0] {
    S_FETCH  = 3'd0,
    S_DECODE = 3'd1,
    S_EXEC   = 3'd2,
    S_MEM    = 3'd3,
    S_WB     = 3'd4,
    S_TRAP   = 3'd7
  } state_t;

  localparam logic [4:0] OP_LUI    = 5'b01101;
  localparam logic [4:0] OP_AUIPC  = 5'b00101;
  localparam logic [4:0] OP_JAL    = 5'b11011;
  localparam logic [4:0] OP_JALR   = 5'b11001;
  localparam logic [4:0] OP_BRANCH = 5'b11000;
  localparam logic [4:0] OP_LOAD   = 5'b00000;
  localparam logic [4:0] OP_STORE  = 5'b01000;
  localparam logic [4:0] OP_OPIMM  = 5'b00100;
  localparam logic [4:0] OP_OP     = 5'b01100;

  state_t      state_q, state_d;
  logic [31:0] instret_q;
  logic        retire;
  logic [4:0]  op;
  logic        is_lui, is_auipc, is_jal, is_jalr, is_branch;
  logic        is_load, is_store, is_opimm, is_op, legal;
  logic        rd_nonzero;
  logic        unused_inst_bits;

  // Opcode decode of the instruction register
  always_comb begin
    op         = inst[6:2];
    is_lui     = (op == OP_LUI);
    is_auipc   = (op == OP_AUIPC);
    is_jal     = (op == OP_JAL);
    is_jalr    = (op == OP_JALR);
    is_branch  = (op == OP_BRANCH);
    is_load    = (op == OP_LOAD);
    is_store   = (op == OP_STORE);
    is_opimm   = (op == OP_OPIMM);
    is_op      = (op == OP_OP);
    legal      = (inst[1:0] == 2'b11) &&
                 (is_lui || is_auipc || is_jal || is_jalr || is_branch ||
                  is_load || is_store || is_opimm || is_op);
    rd_nonzero = (inst[11:7] != 5'd0);
  end

  // Upper instruction bits belong to the immediate builder, not this block
  assign unused_inst_bits = ^inst[31:12];

  // State and retired-instruction counter
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q   <= S_FETCH;
      instret_q <= 32'd0;
    end else begin
      state_q <= state_d;
      if (retire) instret_q <= instret_q + 32'd1;
    end
  end

  // Next state and control outputs; everything is forced low while in reset
  always_comb begin
    state_d   = state_q;
    retire    = 1'b0;
    imem_req  = 1'b0;
    ir_we     = 1'b0;
    pc_we     = 1'b0;
    pc_src    = 2'd0;
    alu_a_sel = 1'b0;
    alu_b_sel = 1'b0;
    rf_we     = 1'b0;
    wb_sel    = 2'd0;
    dmem_req  = 1'b0;
    dmem_we   = 1'b0;
    illegal   = 1'b0;
    state     = reset ? 3'd0 : 3'(state_q);
    instret   = reset ? 32'd0 : instret_q;
    if (!reset) begin
      case (state_q)
        S_FETCH: begin
          imem_req = 1'b1;
          if (imem_ready) begin
            ir_we   = 1'b1;
            state_d = S_DECODE;
          end
        end
        S_DECODE: state_d = legal ? S_EXEC : S_TRAP;
        S_EXEC: begin
          alu_a_sel = is_auipc;
          alu_b_sel = is_opimm || is_load || is_store || is_auipc || is_jalr;
          if (is_branch) begin
            pc_we   = 1'b1;
            pc_src  = branch_taken ? 2'd1 : 2'd0;
            retire  = 1'b1;
            state_d = S_FETCH;
          end else if (is_load || is_store) begin
            state_d = S_MEM;
          end else begin
            state_d = S_WB;
          end
        end
        S_MEM: begin
          dmem_req  = 1'b1;
          dmem_we   = is_store;
          alu_b_sel = 1'b1;
          if (dmem_ready) begin
            if (is_store) begin
              pc_we   = 1'b1;
              retire  = 1'b1;
              state_d = S_FETCH;
            end else begin
              state_d = S_WB;
            end
          end
        end
        S_WB: begin
          rf_we   = rd_nonzero;
          pc_we   = 1'b1;
          retire  = 1'b1;
          state_d = S_FETCH;
          if (is_load)                wb_sel = 2'd1;
          else if (is_jal || is_jalr) wb_sel = 2'd2;
          else if (is_lui)            wb_sel = 2'd3;
          if (is_jal)       pc_src = 2'd1;
          else if (is_jalr) pc_src = 2'd2;
        end
        S_TRAP: illegal = 1'b1;
        default: state_d = S_FETCH;
      endcase
    end
  end

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Directed, table-driven bench for multicycle_ctrl.
module tb_multicycle_ctrl;

  logic        clk, reset;
  logic [31:0] inst;
  logic        imem_ready, dmem_ready, branch_taken;
  logic        imem_req, ir_we, pc_we, rf_we, dmem_req, dmem_we, illegal;
  logic        alu_a_sel, alu_b_sel;
  logic [1:0]  pc_src, wb_sel;
  logic [31:0] instret;
  logic [2:0]  state;

  multicycle_ctrl dut (
    .clk(clk), .reset(reset), .inst(inst), .imem_ready(imem_ready),
    .dmem_ready(dmem_ready), .branch_taken(branch_taken),
    .imem_req(imem_req), .ir_we(ir_we), .pc_we(pc_we), .pc_src(pc_src),
    .alu_a_sel(alu_a_sel), .alu_b_sel(alu_b_sel), .rf_we(rf_we),
    .wb_sel(wb_sel), .dmem_req(dmem_req), .dmem_we(dmem_we),
    .illegal(illegal), .instret(instret), .state(state)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  typedef struct packed {
    logic        rst;
    logic [31:0] inst;
    logic        ir, dr, bt;
  } in_t;

  typedef struct packed {
    logic [2:0]  st;
    logic        imr, irwe, pcwe;
    logic [1:0]  pcs;
    logic        as, bs, rfwe;
    logic [1:0]  wbs;
    logic        dreq, dwe, ill;
    logic [31:0] cnt;
  } out_t;

  typedef struct packed {
    in_t  i;
    out_t o;
  } vec_t;

  vec_t vecs[$];
  int   checks = 0;
  int   errors = 0;

  function automatic out_t o(input logic [2:0] st, input logic imr, irwe, pcwe,
                             input logic [1:0] pcs, input logic as, bs, rfwe,
                             input logic [1:0] wbs, input logic dreq, dwe, ill,
                             input logic [31:0] cnt);
    o = '{st, imr, irwe, pcwe, pcs, as, bs, rfwe, wbs, dreq, dwe, ill, cnt};
  endfunction

  task automatic add(input logic rst, input logic [31:0] ins, input logic ir,
                     dr, bt, input out_t e);
    vecs.push_back('{'{rst, ins, ir, dr, bt}, e});
  endtask

  // FETCH with zero-wait memory followed by DECODE
  task automatic add_fd(input logic [31:0] ins, input logic [31:0] n);
    add(0, ins, 1, 0, 0, o(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, n));
    add(0, ins, 0, 1, 0, o(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, n));
  endtask

  task automatic drive(input in_t v);
    reset = v.rst; inst = v.inst; imem_ready = v.ir;
    dmem_ready = v.dr; branch_taken = v.bt;
  endtask

  task automatic check(input string name, input out_t e);
    out_t a;
    a = '{state, imem_req, ir_we, pc_we, pc_src, alu_a_sel, alu_b_sel, rf_we,
          wb_sel, dmem_req, dmem_we, illegal, instret};
    checks++;
    if (a !== e) begin
      errors++;
      $display("FAIL %s: got %h expected %h", name, a, e);
    end
  endtask

  task automatic apply(input string name, input in_t v, input out_t e);
    drive(v);
    @(negedge clk);
    check(name, e);
    @(posedge clk);
    #1;
  endtask

  localparam logic [31:0] ADDI = 32'h0050_0093;
  localparam logic [31:0] LW   = 32'h0000_A103;
  localparam logic [31:0] BEQ  = 32'h0000_0463;
  localparam logic [31:0] JALR = 32'h0000_8067;
  localparam logic [31:0] AUIP = 32'h0000_0197;
  localparam logic [31:0] LUI  = 32'h0000_0237;
  localparam logic [31:0] JAL  = 32'h0000_00EF;
  localparam logic [31:0] ADD  = 32'h0020_81B3;
  localparam logic [31:0] SW   = 32'h0020_A023;
  localparam logic [31:0] BAD  = 32'h0000_007F;
  localparam logic [31:0] BAD2 = 32'h0000_0010;

  initial begin
    out_t z;
    z = o(0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0);

    // reset, then ADDI with one fetch wait cycle
    add(1, ADDI, 1, 1, 1, z);
    add(1, ADDI, 1, 1, 1, z);
    add(0, ADDI, 0, 1, 0, o(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    add_fd(ADDI, 0);
    add(0, ADDI, 0, 0, 0, o(2, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    add(0, ADDI, 0, 0, 0, o(4, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 0));
    // LW with three data wait cycles
    add_fd(LW, 1);
    add(0, LW, 0, 0, 0, o(2, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 1));
    for (int k = 0; k < 3; k++)
      add(0, LW, 1, 0, 0, o(3, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1));
    add(0, LW, 0, 1, 0, o(3, 0, 0, 0, 0, 0, 1, 0, 0, 1, 0, 0, 1));
    add(0, LW, 0, 0, 0, o(4, 0, 0, 1, 0, 0, 0, 1, 1, 0, 0, 0, 1));
    // BEQ taken, then not taken
    add_fd(BEQ, 2);
    add(0, BEQ, 0, 0, 1, o(2, 0, 0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 2));
    add_fd(BEQ, 3);
    add(0, BEQ, 0, 0, 0, o(2, 0, 0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 3));
    // JALR x0: no register write
    add_fd(JALR, 4);
    add(0, JALR, 0, 0, 0, o(2, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 4));
    add(0, JALR, 0, 0, 0, o(4, 0, 0, 1, 2, 0, 0, 0, 2, 0, 0, 0, 4));
    // AUIPC, LUI, JAL, OP
    add_fd(AUIP, 5);
    add(0, AUIP, 0, 0, 0, o(2, 0, 0, 0, 0, 1, 1, 0, 0, 0, 0, 0, 5));
    add(0, AUIP, 0, 0, 0, o(4, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 5));
    add_fd(LUI, 6);
    add(0, LUI, 0, 0, 0, o(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 6));
    add(0, LUI, 0, 0, 0, o(4, 0, 0, 1, 0, 0, 0, 1, 3, 0, 0, 0, 6));
    add_fd(JAL, 7);
    add(0, JAL, 0, 0, 0, o(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 7));
    add(0, JAL, 0, 0, 0, o(4, 0, 0, 1, 1, 0, 0, 1, 2, 0, 0, 0, 7));
    add_fd(ADD, 8);
    add(0, ADD, 0, 0, 0, o(2, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 8));
    add(0, ADD, 0, 0, 0, o(4, 0, 0, 1, 0, 0, 0, 1, 0, 0, 0, 0, 8));
    // SW interrupted by reset while waiting on data memory
    add_fd(SW, 9);
    add(0, SW, 0, 0, 0, o(2, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 9));
    add(0, SW, 0, 0, 0, o(3, 0, 0, 0, 0, 0, 1, 0, 0, 1, 1, 0, 9));
    add(1, SW, 1, 1, 1, z);
    add(0, SW, 0, 0, 0, o(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // SW completing with zero-wait memory
    add_fd(SW, 0);
    add(0, SW, 0, 1, 0, o(2, 0, 0, 0, 0, 0, 1, 0, 0, 0, 0, 0, 0));
    add(0, SW, 0, 1, 0, o(3, 0, 0, 1, 0, 0, 1, 0, 0, 1, 1, 0, 0));
    // illegal opcode reaches DECODE
    add_fd(BAD, 1);

    foreach (vecs[k]) apply($sformatf("vec%0d", k), vecs[k].i, vecs[k].o);

    // Trap is sticky and ignores ready inputs for 20 cycles
    for (int k = 0; k < 20; k++)
      apply($sformatf("trap%0d", k), '{0, BAD, k[0], k[1], k[2]},
            o(7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 1));
    apply("trap_reset", '{1, BAD, 0, 0, 0}, z);
    apply("post_reset", '{0, BAD2, 1, 0, 0},
          o(0, 1, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    // Legal-looking opcode with inst[1:0] != 2'b11 also traps
    apply("bad2_dec", '{0, BAD2, 0, 0, 0}, o(1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));
    apply("bad2_trap", '{0, BAD2, 1, 1, 0}, o(7, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 1, 0));
    apply("final_reset", '{1, BAD2, 1, 1, 1}, z);
    apply("final_fetch", '{0, ADDI, 0, 0, 0},
          o(0, 1, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0, 0));

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
# multicycle_ctrl

Multi-cycle control sequencer for the RV32I core. Each instruction moves through fetch, decode, execute, memory and write-back steps. The block decodes the opcode of the instruction register, which also feeds the immediate builder. It drives the enable and select lines for the PC, instruction register, ALU operand muxes, register file, data memory and write-back mux. It also keeps a retired-instruction counter and latches a trap on illegal opcodes.

## Interface
- No parameters.
- clk  in  1  system clock; all state changes on the rising edge.
- reset  in  1  synchronous, active-high reset.
- inst  in  32  instruction register contents; valid from DECODE onward.
- imem_ready  in  1  instruction memory done; sampled only while imem_req=1.
- dmem_ready  in  1  data memory done; sampled only while dmem_req=1.
- branch_taken  in  1  branch comparator result; sampled in EXEC.
- imem_req  out  1  instruction fetch request.
- ir_we  out  1  instruction register write enable.
- pc_we  out  1  PC write enable.
- pc_src  out  2  next-PC source: 0 = PC+4, 1 = PC+imm, 2 = {alu_result[31:1], 1'b0}.
- alu_a_sel  out  1  ALU operand A: 0 = rs1, 1 = PC.
- alu_b_sel  out  1  ALU operand B: 0 = rs2, 1 = imm.
- rf_we  out  1  register file write enable.
- wb_sel  out  2  write-back source: 0 = ALU, 1 = memory, 2 = PC+4, 3 = imm.
- dmem_req  out  1  data memory request.
- dmem_we  out  1  data memory write (store).
- illegal  out  1  trap flag; sticky until reset.
- instret  out  32  retired-instruction count.
- state  out  3  current state, for debug.

## Operation
- States and encodings: FETCH = 0, DECODE = 1, EXEC = 2, MEM = 3, WB = 4, TRAP = 7.
- The opcode is op = inst[6:2]. Legal only if inst[1:0] = 2'b11 and op is one of:
  - LUI 01101, AUIPC 00101, JAL 11011, JALR 11001
  - BRANCH 11000, LOAD 00000, STORE 01000
  - OP-IMM 00100, OP 01100
- FETCH:
  - imem_req = 1.
  - When imem_ready = 1: ir_we = 1 in that cycle, next state DECODE. Otherwise stay in FETCH.
- DECODE: if inst is illegal, go to TRAP. Otherwise go to EXEC.
- EXEC:
  - alu_a_sel = 1 for AUIPC only.
  - alu_b_sel = 1 for OP-IMM, LOAD, STORE, AUIPC and JALR.
  - BRANCH: pc_we = 1, pc_src = branch_taken ? 1 : 0, next state FETCH. The instruction retires here.
  - LOAD or STORE: next state MEM.
  - All other legal opcodes: next state WB.
- MEM:
  - dmem_req = 1; dmem_we = 1 for STORE.
  - ALU operand selects hold their EXEC values.
  - Stay in MEM until dmem_ready = 1.
  - On ready, STORE: pc_we = 1, pc_src = 0, next state FETCH. The instruction retires here.
  - On ready, LOAD: next state WB.
- WB:
  - rf_we = 1 unless inst[11:7] = 0.
  - wb_sel per opcode: LOAD 1; JAL and JALR 2; LUI 3; OP, OP-IMM and AUIPC 0.
  - pc_we = 1; pc_src is 1 for JAL, 2 for JALR, else 0.
  - The instruction retires; next state FETCH.
- TRAP:
  - illegal = 1. All other outputs 0.
  - No exit except reset.
- instret increments by 1 in every retire cycle and wraps from 0xFFFFFFFF to 0.
- Any output not listed for a state is 0 in that state.

## Timing
- Reset:
  - While reset = 1, state becomes FETCH and instret becomes 0 at the next edge.
  - All outputs are 0 during any cycle with reset = 1, including imem_req and illegal.
  - imem_req first asserts in the cycle after reset deasserts.
- Reset mid-operation: reset asserted in any state, including during a pending request, drops the request the same cycle. Nothing retires and no pc_we or rf_we pulse occurs.
- Requests are level signals held until ready. Any number of wait cycles is allowed. A ready input seen while the matching request is low has no effect.
- All outputs are combinational from state, inst, imem_ready, dmem_ready and branch_taken. Only state and instret are registered.
- Latency in cycles, with zero-wait memories (ready high on the first request cycle):
  - BRANCH: 3
  - STORE: 4
  - OP, OP-IMM, LUI, AUIPC, JAL, JALR: 4
  - LOAD: 5
- Each memory wait cycle adds exactly 1 cycle.
- pc_we, ir_we and rf_we are single-cycle pulses per instruction.

## Test plan
- ADDI x1,x0,5 (0x00500093), zero-wait memories -> states 0, 1, 2, 4, 0. In WB: rf_we = 1, wb_sel = 0, pc_we = 1, pc_src = 0. instret goes 0 -> 1.
- LW x2,0(x1) with dmem_ready held low for 3 MEM cycles -> dmem_req high for 4 cycles with dmem_we = 0. Then WB with wb_sel = 1. Total latency 8 cycles.
- BEQ, once with branch_taken = 1 and once with 0 -> EXEC gives pc_we = 1 with pc_src = 1 and 0 respectively. No rf_we pulse. instret +1 each.
- JALR x0,0(x1) (0x00008067) -> WB gives pc_src = 2, wb_sel = 2, rf_we = 0 because rd = 0.
- inst = 0x0000007F (illegal opcode) -> TRAP after DECODE, illegal = 1 held for 20 cycles, instret unchanged. Reset -> illegal = 0, state = 0.
- Reset asserted in MEM during a STORE wait -> dmem_req drops the same cycle, no pc_we pulse, FETCH resumes after reset with instret = 0.
